reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Generates the ordered reset signals consumed by the team's flip-flop and register blocks, which have asynchronous active-low reset inputs.
- On reset entry, all outputs assert immediately.
- On release, the sequencer synchronizes deassertion to clk and releases NUM_OUTS downstream resets one at a time, HOLD_CYCLES apart.
- It also accepts a synchronous software reset request, which replays the same sequence without a power-on reset.

Parameters:
- SYNC_STAGES, 2: depth of the deassertion synchronizer; legal range is 2 or more.
- NUM_OUTS, 4: number of sequenced reset outputs; legal range is 1 or more.
- HOLD_CYCLES, 8: clk cycles between successive releases, and the duration of a software-reset assertion; legal range is 1 or more.
- CNT_W, $clog2(HOLD_CYCLES+1): width of the hold counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low master reset; assertion acts immediately and does not wait for clk.
- sw_req  input  1  synchronous software reset request; 1-cycle pulse, sampled on the clk rising edge.
- rst_n_out  output  NUM_OUTS  sequenced active-low resets; bit 0 releases first.
- rst_out  output  NUM_OUTS  active-high copies; combinational ~rst_n_out.
- busy  output  1  high while any rst_n_out bit is 0.
- done  output  1  high when all outputs have been released.

Behaviour:
Reset:
- While reset=0: rst_n_out=0, rst_out=all ones, busy=1, done=0, synchronizer chain=0, counter=0, index=0, state=HOLD.
- This applies asynchronously, including mid-sequence and while in DONE.

Synchronizer:
- A chain of SYNC_STAGES flops; each is asynchronously cleared by reset and shifts in 1.
- Define edge 1 as the first clk rising edge after reset rises. rst_sync becomes 1 after edge SYNC_STAGES.

State HOLD:
- All outputs are held asserted.
- When rst_sync=1 at an edge: go to WAIT with counter=0 and index=0.

State WAIT:
- Counter increments each edge.
- At the edge where counter==HOLD_CYCLES-1:
  - rst_n_out[index] goes to 1;
  - counter clears to 0;
  - index increments.
- If index was NUM_OUTS-1, go to DONE on that same edge.
- Released bits stay at 1; bits are never released out of order.

State DONE:
- done=1, busy=0.
- sw_req=1 at an edge: rst_n_out returns to 0 on that edge, done goes to 0 on that edge, counter clears, state goes to SWHOLD.

State SWHOLD:
- Counter counts HOLD_CYCLES edges; at the edge where counter==HOLD_CYCLES-1, go to WAIT with counter=0 and index=0.
- No synchronizer involvement.

Ignored requests:
- sw_req in HOLD, WAIT or SWHOLD is ignored; it is not queued.

Timing with defaults (SYNC_STAGES=2, HOLD_CYCLES=8, NUM_OUTS=4):
- Power-on release: FSM leaves HOLD at edge 3. rst_n_out[0] rises at edge 11, [1] at 19, [2] at 27, [3] at 35. done=1 from edge 35.
- Software reset: sw_req sampled at edge E gives all-zero outputs after E, WAIT entered at E+8, bit 0 released at E+16, done at E+40.

Edge cases:
- A reset glitch shorter than one clk period still clears all state; the sequence restarts from edge 1 of the next release.
- reset and sw_req together: reset dominates.
- HOLD_CYCLES=1: one output releases per edge.
- NUM_OUTS=1: done rises on the same edge as the single release.

Output and counter constraints:
- All outputs are registered except rst_out, done and busy, which decode from registered state.
- The counter never exceeds HOLD_CYCLES-1.

Decomposition:
- Package reset_seq_pkg:
  - state enum {HOLD, WAIT, DONE, SWHOLD} with 2-bit encoding;
  - a localparam function for CNT_W;
  - the default SYNC_STAGES and HOLD_CYCLES constants.
- Sub-module reset_sync:
  - SYNC_STAGES-deep synchronizer with asynchronous active-low clear;
  - ports clk, reset, rst_sync;
  - reusable by other blocks.

Test Plan:
1. Power-on: reset=0 for 5 cycles, then release with defaults -> rst_n_out=0000 at edges 1-10, 0001 at 11, 0011 at 19, 0111 at 27, 1111 at 35; done rises at 35.
2. Asynchronous assert mid-sequence: drop reset between edges 20 and 21 -> rst_n_out=0000 and done=0 immediately, before edge 21; after release, the sequence restarts with bit 0 at new edge 11.
3. Software reset: sw_req pulse at edge E in DONE -> rst_n_out=0000 after E, 0001 at E+16, 1111 and done=1 at E+40.
4. Ignored request: sw_req at edge 15, while in WAIT -> timing identical to scenario 1.
5. Simultaneous events: reset falls in the same cycle sw_req is high in DONE -> outputs cleared asynchronously; restart timing identical to scenario 1.
6. Parameter sweep (NUM_OUTS=1, HOLD_CYCLES=1, SYNC_STAGES=3) -> rst_n_out=1 and done=1 at edge 5; rst_out is always ~rst_n_out.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the reset sequencer and its synchronizer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    WAIT   = 2'd1,
    DONE   = 2'd2,
    SWHOLD = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_CYCLES = 8;
  localparam int DEF_NUM_OUTS    = 4;

  function automatic int cnt_width(input int hold_cycles);
    return $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset deassertion synchronizer: asserts asynchronously, releases after
// SYNC_STAGES rising edges of clk.
module reset_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic rst_sync
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) chain <= '0;
    else        chain <= {chain[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset release: NUM_OUTS active-low resets freed one at a time,
// HOLD_CYCLES apart, after power-on or a software reset request.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int NUM_OUTS    = DEF_NUM_OUTS,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int CNT_W       = cnt_width(HOLD_CYCLES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sw_req,
  output logic [NUM_OUTS-1:0] rst_n_out,
  output logic [NUM_OUTS-1:0] rst_out,
  output logic                busy,
  output logic                done
);

  localparam int IDX_W = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OUTS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             rst_sync;

  reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .rst_sync (rst_sync)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HOLD;
      cnt       <= '0;
      idx       <= '0;
      rst_n_out <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (rst_sync) begin
            state <= WAIT;
            cnt   <= '0;
            idx   <= '0;
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            // idx only ever walks upward, so bits release strictly in order
            rst_n_out[idx] <= 1'b1;
            cnt            <= '0;
            idx            <= idx + 1'b1;
            if (idx == IDX_LAST) state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (sw_req) begin
            rst_n_out <= '0;
            cnt       <= '0;
            state     <= SWHOLD;
          end
        end
        SWHOLD: begin
          if (cnt == CNT_LAST) begin
            state <= WAIT;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

  assign rst_out = ~rst_n_out;
  assign busy    = ~&rst_n_out;
  assign done    = (state == DONE);

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: an arithmetic release-time model pushes expected outputs
// every edge; a negedge monitor pops and compares for two parameter sets.
module tb_reset_sequencer;

  localparam int N0 = 4, H0 = 8, S0 = 2;
  localparam int N1 = 1, H1 = 1, S1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    reset  = 2'b00;
  logic [1:0]    sw_req = 2'b00;
  logic [N0-1:0] rn0, ro0;
  logic [N1-1:0] rn1, ro1;
  logic          b0, d0, b1, d1;

  reset_sequencer #(.SYNC_STAGES(S0), .NUM_OUTS(N0), .HOLD_CYCLES(H0)) dut0 (
    .clk(clk), .reset(reset[0]), .sw_req(sw_req[0]),
    .rst_n_out(rn0), .rst_out(ro0), .busy(b0), .done(d0)
  );

  reset_sequencer #(.SYNC_STAGES(S1), .NUM_OUTS(N1), .HOLD_CYCLES(H1)) dut1 (
    .clk(clk), .reset(reset[1]), .sw_req(sw_req[1]),
    .rst_n_out(rn1), .rst_out(ro1), .busy(b1), .done(d1)
  );

  typedef struct {
    logic [7:0] rn;
    logic       dn;
  } exp_t;

  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int checks = 0, errors = 0;

  // Model: edges since reset rose, and the edge at which releasing begins.
  int nout[2] = '{N0, N1};
  int hold[2] = '{H0, H1};
  int rel[2]   = '{0, 0};
  int start[2] = '{S0 + 1, S1 + 1};

  function automatic int released(input int i);
    int r;
    if (rel[i] < start[i]) return 0;
    r = (rel[i] - start[i]) / hold[i];
    return (r > nout[i]) ? nout[i] : r;
  endfunction

  always @(negedge reset[0]) begin rel[0] = 0; start[0] = S0 + 1; end
  always @(negedge reset[1]) begin rel[1] = 0; start[1] = S1 + 1; end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      if (reset[i]) begin
        if (sw_req[i] && released(i) == nout[i]) start[i] = rel[i] + 1 + hold[i];
        rel[i] = rel[i] + 1;
      end
      e.rn = 8'((1 << released(i)) - 1);
      e.dn = (released(i) == nout[i]);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      chk("rst_n_out0", 8'(rn0), e0.rn);
      chk("done0", 8'(d0), 8'(e0.dn));
      chk("busy0", 8'(b0), 8'(!e0.dn));
      chk("rst_out0", 8'(ro0), ~e0.rn & 8'h0F);
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      chk("rst_n_out1", 8'(rn1), e1.rn);
      chk("done1", 8'(d1), 8'(e1.dn));
      chk("busy1", 8'(b1), 8'(!e1.dn));
      chk("rst_out1", 8'(ro1), ~e1.rn & 8'h01);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic async_chk(input string nm);
    chk({nm, "_rn0"}, 8'(rn0), 8'h00);
    chk({nm, "_done0"}, 8'(d0), 8'h00);
    chk({nm, "_rn1"}, 8'(rn1), 8'h00);
    chk({nm, "_done1"}, 8'(d1), 8'h00);
  endtask

  initial begin
    step(5);
    // power-on release, with an ignored request at edge 15 on the wide instance
    reset = 2'b11;
    step(14);
    sw_req = 2'b01;
    step(1);
    sw_req = 2'b00;
    step(30);
    // software reset from DONE on both instances
    sw_req = 2'b11;
    step(1);
    sw_req = 2'b00;
    step(45);
    // asynchronous drop between edges 20 and 21
    reset = 2'b00;
    step(2);
    reset = 2'b11;
    step(20);
    reset = 2'b00;
    #1 async_chk("mid_seq");
    step(2);
    reset = 2'b11;
    step(45);
    // sub-cycle glitch while in DONE
    reset = 2'b00;
    #1 async_chk("glitch");
    #1 reset = 2'b11;
    step(45);
    // reset and software request together
    sw_req = 2'b11;
    reset  = 2'b00;
    #1 async_chk("simul");
    step(1);
    sw_req = 2'b00;
    step(2);
    reset = 2'b11;
    step(45);
    // randomized requests and reset drops
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        sw_req[i] = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 149) == 0)    reset[i] = 1'b0;
        else if ($urandom_range(0, 2) == 0) reset[i] = 1'b1;
      end
      step(1);
    end
    sw_req = 2'b00;
    reset  = 2'b11;
    step(45);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
